reorder_buffer: RTL

Circular 16-entry reorder buffer that accepts completion writes from the three functional-unit result ports (ALU1, ALU2, MEM) and retires results in program order, two per cycle. It is the receiving end of the FU→complete interface: allocation comes from the rename/RS stage, completion tags come from the FU output buffer, and the retire outputs drive register-file writes and free-list returns.

---
 rtl/reorder_buffer_if.sv | 46 ++++
 rtl/reorder_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Allocation, completion and retire bundle between rename/RS, the FU result ports and the ROB.
// The master side drives allocation and completions; the slave side (the ROB) drives retire/free.
interface reorder_buffer_if #(
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
);
  logic              alloc_en1, alloc_en2;
  logic [PREG_W-1:0] alloc_pd1, alloc_pd2;
  logic [PREG_W-1:0] alloc_old_pd1, alloc_old_pd2;
  logic              alloc_regwr1, alloc_regwr2;
  logic              alloc_ready;
  logic [IDX_W-1:0]  rob_tail;

  logic              cmp_valid1, cmp_valid2, cmp_valid3;
  logic [IDX_W-1:0]  cmp_idx1, cmp_idx2, cmp_idx3;
  logic [DATA_W-1:0] cmp_data1, cmp_data2, cmp_data3;

  logic              ret_valid1, ret_valid2;
  logic              ret_wren1, ret_wren2;
  logic [PREG_W-1:0] ret_pd1, ret_pd2;
  logic [DATA_W-1:0] ret_data1, ret_data2;
  logic              free_valid1, free_valid2;
  logic [PREG_W-1:0] free_pd1, free_pd2;
  logic [IDX_W:0]    count;

  modport master (
    output alloc_en1, alloc_en2, alloc_pd1, alloc_pd2, alloc_old_pd1, alloc_old_pd2,
           alloc_regwr1, alloc_regwr2,
           cmp_valid1, cmp_valid2, cmp_valid3, cmp_idx1, cmp_idx2, cmp_idx3,
           cmp_data1, cmp_data2, cmp_data3,
    input  alloc_ready, rob_tail, ret_valid1, ret_valid2, ret_wren1, ret_wren2,
           ret_pd1, ret_pd2, ret_data1, ret_data2, free_valid1, free_valid2,
           free_pd1, free_pd2, count
  );

  modport slave (
    input  alloc_en1, alloc_en2, alloc_pd1, alloc_pd2, alloc_old_pd1, alloc_old_pd2,
           alloc_regwr1, alloc_regwr2,
           cmp_valid1, cmp_valid2, cmp_valid3, cmp_idx1, cmp_idx2, cmp_idx3,
           cmp_data1, cmp_data2, cmp_data3,
    output alloc_ready, rob_tail, ret_valid1, ret_valid2, ret_wren1, ret_wren2,
           ret_pd1, ret_pd2, ret_data1, ret_data2, free_valid1, free_valid2,
           free_pd1, free_pd2, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: dual allocate, three completion ports, in-order dual retire.
// Each slot is a reorder_buffer_entry; the top owns head/tail/count and the retire registers.
module reorder_buffer_entry #(
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc,
  input  logic                   alloc_regwr,
  input  logic [PREG_W-1:0]      alloc_pd,
  input  logic [PREG_W-1:0]      alloc_old_pd,
  input  logic                   retire,
  input  logic [2:0]             cmp_hit,
  input  logic [2:0][DATA_W-1:0] cmp_data,
  output logic                   valid,
  output logic                   done,
  output logic                   regwr,
  output logic [PREG_W-1:0]      pd,
  output logic [PREG_W-1:0]      old_pd,
  output logic [DATA_W-1:0]      data
);
  logic              cmp_any;
  logic [DATA_W-1:0] cmp_sel;

  // Higher port number wins when several ports complete this slot together.
  always_comb begin
    cmp_sel = cmp_data[0];
    if (cmp_hit[1]) cmp_sel = cmp_data[1];
    if (cmp_hit[2]) cmp_sel = cmp_data[2];
  end

  assign cmp_any = (|cmp_hit) & valid;

  // Allocation overrides a same-cycle completion so a reused slot starts not-done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      done   <= 1'b0;
      regwr  <= 1'b0;
      pd     <= '0;
      old_pd <= '0;
      data   <= '0;
    end else if (alloc) begin
      valid  <= 1'b1;
      done   <= 1'b0;
      regwr  <= alloc_regwr;
      pd     <= alloc_pd;
      old_pd <= alloc_old_pd;
    end else if (retire) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (cmp_any) begin
      done <= 1'b1;
      data <= cmp_sel;
    end
  end
endmodule

module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  reorder_buffer_if.slave rob
);
  logic [DEPTH-1:0]             e_valid, e_done, e_regwr;
  logic [DEPTH-1:0][PREG_W-1:0] e_pd, e_old_pd;
  logic [DEPTH-1:0][DATA_W-1:0] e_data;

  logic [IDX_W-1:0] head, tail, head1, a1_idx, a2_idx;
  logic [IDX_W:0]   cnt;
  logic             ready, do_a1, do_a2, ret1, ret2, fr1, fr2;

  logic [2:0]             cmp_v;
  logic [2:0][IDX_W-1:0]  cmp_idx;
  logic [2:0][DATA_W-1:0] cmp_d;

  assign cmp_v   = {rob.cmp_valid3, rob.cmp_valid2, rob.cmp_valid1};
  assign cmp_idx = {rob.cmp_idx3, rob.cmp_idx2, rob.cmp_idx1};
  assign cmp_d   = {rob.cmp_data3, rob.cmp_data2, rob.cmp_data1};

  assign ready  = (cnt <= (IDX_W+1)'(DEPTH-2));
  assign do_a1  = ready & rob.alloc_en1;
  assign do_a2  = ready & rob.alloc_en2;
  assign a1_idx = tail;
  // A lone port-2 request takes the tail slot itself.
  assign a2_idx = do_a1 ? tail + IDX_W'(1) : tail;

  assign head1 = head + IDX_W'(1);
  assign ret1  = e_valid[head] & e_done[head];
  assign ret2  = ret1 & e_valid[head1] & e_done[head1];
  assign fr1   = ret1 & e_regwr[head]  & (e_old_pd[head]  != '0);
  assign fr2   = ret2 & e_regwr[head1] & (e_old_pd[head1] != '0);

  assign rob.alloc_ready = ready;
  assign rob.rob_tail    = tail;
  assign rob.count       = cnt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic       hit1, hit2, ret_hit;
    logic [2:0] hit;
    assign hit1    = do_a1 & (a1_idx == IDX_W'(i));
    assign hit2    = do_a2 & (a2_idx == IDX_W'(i));
    assign ret_hit = (ret1 & (head == IDX_W'(i))) | (ret2 & (head1 == IDX_W'(i)));
    for (genvar p = 0; p < 3; p++) begin : g_cmp
      assign hit[p] = cmp_v[p] & (cmp_idx[p] == IDX_W'(i));
    end

    reorder_buffer_entry #(.PREG_W(PREG_W), .DATA_W(DATA_W)) u_ent (
      .clk          (clk),
      .rst_n        (rst_n),
      .alloc        (hit1 | hit2),
      .alloc_regwr  (hit2 ? rob.alloc_regwr2  : rob.alloc_regwr1),
      .alloc_pd     (hit2 ? rob.alloc_pd2     : rob.alloc_pd1),
      .alloc_old_pd (hit2 ? rob.alloc_old_pd2 : rob.alloc_old_pd1),
      .retire       (ret_hit),
      .cmp_hit      (hit),
      .cmp_data     (cmp_d),
      .valid        (e_valid[i]),
      .done         (e_done[i]),
      .regwr        (e_regwr[i]),
      .pd           (e_pd[i]),
      .old_pd       (e_old_pd[i]),
      .data         (e_data[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + IDX_W'(ret1) + IDX_W'(ret2);
      tail <= tail + IDX_W'(do_a1) + IDX_W'(do_a2);
      cnt  <= cnt + (IDX_W+1)'(do_a1) + (IDX_W+1)'(do_a2)
                  - (IDX_W+1)'(ret1) - (IDX_W+1)'(ret2);
    end
  end

  // Retire ports are registered and forced to zero when the slot does not retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rob.ret_valid1  <= 1'b0;
      rob.ret_valid2  <= 1'b0;
      rob.ret_wren1   <= 1'b0;
      rob.ret_wren2   <= 1'b0;
      rob.ret_pd1     <= '0;
      rob.ret_pd2     <= '0;
      rob.ret_data1   <= '0;
      rob.ret_data2   <= '0;
      rob.free_valid1 <= 1'b0;
      rob.free_valid2 <= 1'b0;
      rob.free_pd1    <= '0;
      rob.free_pd2    <= '0;
    end else begin
      rob.ret_valid1  <= ret1;
      rob.ret_valid2  <= ret2;
      rob.ret_wren1   <= ret1 & e_regwr[head];
      rob.ret_wren2   <= ret2 & e_regwr[head1];
      rob.ret_pd1     <= ret1 ? e_pd[head]    : '0;
      rob.ret_pd2     <= ret2 ? e_pd[head1]   : '0;
      rob.ret_data1   <= ret1 ? e_data[head]  : '0;
      rob.ret_data2   <= ret2 ? e_data[head1] : '0;
      rob.free_valid1 <= fr1;
      rob.free_valid2 <= fr2;
      rob.free_pd1    <= fr1 ? e_old_pd[head]  : '0;
      rob.free_pd2    <= fr2 ? e_old_pd[head1] : '0;
    end
  end
endmodule
